// File: rtl/mul_pkg.sv
// Shared constants and fixed-point helpers for the multiplier family.
package mul_pkg;

    // Reference operand width; the pipeline derives its own product width from WIDTH.
    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned PROD_W        = 2 * DEFAULT_WIDTH;

    // Register stages between operand accept and result presentation.
    localparam int unsigned LATENCY = 3;

    // Widest result the saturation helper produces, and its input width.
    localparam int unsigned SAT_MAX_W  = 64;
    localparam int unsigned SAT_MAX_IN = 2 * SAT_MAX_W + 1;

    // Clamp v into out_w bits, either as two's complement or as unsigned.
    // v must already be sign-extended (signed) or zero-extended (unsigned) to
    // SAT_MAX_IN bits. Returns {clamped, result}; result bits above out_w are 0.
    function automatic logic [SAT_MAX_W:0] saturate(
        input logic [SAT_MAX_IN-1:0] v,
        input int unsigned           out_w,
        input logic                  is_signed
    );
        logic [SAT_MAX_W-1:0] res;
        logic                 clamp;
        logic                 neg;
        res   = '0;
        clamp = 1'b0;
        neg   = v[SAT_MAX_IN-1];
        for (int i = 0; i < SAT_MAX_IN; i++) begin
            if (is_signed) begin
                // In range only if every bit from the result MSB upward matches the sign.
                if (i >= out_w - 1 && v[i] != neg) begin
                    clamp = 1'b1;
                end
            end else if (i >= out_w && v[i]) begin
                clamp = 1'b1;
            end
        end
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < out_w) begin
                if (!clamp) begin
                    res[i] = v[i];
                end else if (is_signed) begin
                    // Negative clamps to 100..0, positive to 011..1.
                    res[i] = (i == out_w - 1) ? neg : ~neg;
                end else begin
                    res[i] = 1'b1;
                end
            end
        end
        return {clamp, res};
    endfunction

endpackage

// File: rtl/vedic_mul_core.sv
// Combinational unsigned W x W -> 2W Vedic (Urdhva Tiryagbhyam) multiplier.
// Splits each operand into halves and recurses down to a 2-bit gate-level base.
module vedic_mul_core #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    localparam int unsigned PW = 2 * W;

    if (W == 2) begin : g_base
        logic t_lo_cross;
        logic t_hi_cross;
        logic t_hh;
        logic c1;

        // 2x2 base case: vertical and crosswise partial products with half adders.
        assign t_lo_cross = a_i[1] & b_i[0];
        assign t_hi_cross = a_i[0] & b_i[1];
        assign t_hh       = a_i[1] & b_i[1];
        assign c1         = t_lo_cross & t_hi_cross;
        assign p_o[0]     = a_i[0] & b_i[0];
        assign p_o[1]     = t_lo_cross ^ t_hi_cross;
        assign p_o[2]     = t_hh ^ c1;
        assign p_o[3]     = t_hh & c1;
    end else begin : g_rec
        localparam int unsigned HW = W / 2;

        logic [W-1:0] pp_hh;
        logic [W-1:0] pp_hl;
        logic [W-1:0] pp_lh;
        logic [W-1:0] pp_ll;

        vedic_mul_core #(.W(HW)) u_hh (
            .a_i (a_i[W-1:HW]),
            .b_i (b_i[W-1:HW]),
            .p_o (pp_hh)
        );

        vedic_mul_core #(.W(HW)) u_hl (
            .a_i (a_i[W-1:HW]),
            .b_i (b_i[HW-1:0]),
            .p_o (pp_hl)
        );

        vedic_mul_core #(.W(HW)) u_lh (
            .a_i (a_i[HW-1:0]),
            .b_i (b_i[W-1:HW]),
            .p_o (pp_lh)
        );

        vedic_mul_core #(.W(HW)) u_ll (
            .a_i (a_i[HW-1:0]),
            .b_i (b_i[HW-1:0]),
            .p_o (pp_ll)
        );

        // Recombine: hh at weight 2^W, the two cross terms at 2^HW, ll at 2^0.
        assign p_o = PW'(pp_ll)
                   + (PW'(pp_hl) << HW)
                   + (PW'(pp_lh) << HW)
                   + {pp_hh, {W{1'b0}}};
    end

endmodule

// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined Vedic multiplier with valid/ready handshakes,
// per-transaction signed/unsigned mode and a rounded, saturated Q-format result.
module vedic_mul_pipe
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               signed_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic [WIDTH-1:0]   q,
    output logic               ovf
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned H      = WIDTH / 2;
    localparam int unsigned RND_SH = (FRAC == 0) ? 0 : FRAC - 1;
    // Half an LSB of the Q result; nothing to round when there are no fraction bits.
    localparam logic [PW:0] RND    = (FRAC == 0) ? '0 : ({{PW{1'b0}}, 1'b1} << RND_SH);

    // Pipeline control: bit 0 = S1, bit 1 = S2, bit LATENCY-1 = output stage.
    logic               adv;
    logic [LATENCY-1:0] vld_d, vld_q;

    // S1: operand magnitudes and the four half-width cross products.
    logic [WIDTH-1:0] mag_x, mag_y;
    logic [WIDTH-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
    logic [WIDTH-1:0] pp_hh_d, pp_hh_q;
    logic [WIDTH-1:0] pp_hl_d, pp_hl_q;
    logic [WIDTH-1:0] pp_lh_d, pp_lh_q;
    logic [WIDTH-1:0] pp_ll_d, pp_ll_q;
    logic             s1_neg_d, s1_neg_q;
    logic             s1_sgn_d, s1_sgn_q;

    // S2: recombined, signed product.
    logic [PW-1:0] s2_mag;
    logic [PW-1:0] s2_prod_d, s2_prod_q;
    logic          s2_sgn_d, s2_sgn_q;

    // S3: rounding, scaling and saturation.
    logic [PW:0]           rnd_sum;
    logic [PW:0]           sh_arith, sh_logic, sh_sel;
    logic [SAT_MAX_IN-1:0] sat_in;
    logic [SAT_MAX_W:0]    sat_res;
    logic                  unused_sat;
    logic [PW-1:0]         out_d, out_q;
    logic [WIDTH-1:0]      q_d, q_q;
    logic                  ovf_d, ovf_q;

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_x = (signed_en && x[WIDTH-1]) ? -x : x;
        mag_y = (signed_en && y[WIDTH-1]) ? -y : y;
    end

    vedic_mul_core #(.W(H)) u_pp_hh (
        .a_i (mag_x[WIDTH-1:H]),
        .b_i (mag_y[WIDTH-1:H]),
        .p_o (pp_hh)
    );

    vedic_mul_core #(.W(H)) u_pp_hl (
        .a_i (mag_x[WIDTH-1:H]),
        .b_i (mag_y[H-1:0]),
        .p_o (pp_hl)
    );

    vedic_mul_core #(.W(H)) u_pp_lh (
        .a_i (mag_x[H-1:0]),
        .b_i (mag_y[WIDTH-1:H]),
        .p_o (pp_lh)
    );

    vedic_mul_core #(.W(H)) u_pp_ll (
        .a_i (mag_x[H-1:0]),
        .b_i (mag_y[H-1:0]),
        .p_o (pp_ll)
    );

    // Recombine the registered cross products and restore the sign.
    always_comb begin
        s2_mag = PW'(pp_ll_q)
               + (PW'(pp_hl_q) << H)
               + (PW'(pp_lh_q) << H)
               + {pp_hh_q, {WIDTH{1'b0}}};
    end

    // Round half-up, scale by FRAC (arithmetic in signed mode) and saturate to WIDTH.
    always_comb begin
        rnd_sum  = {s2_sgn_q & s2_prod_q[PW-1], s2_prod_q} + RND;
        sh_arith = $signed(rnd_sum) >>> FRAC;
        sh_logic = rnd_sum >> FRAC;
        sh_sel   = s2_sgn_q ? sh_arith : sh_logic;
        sat_in   = {{(SAT_MAX_IN - PW - 1){s2_sgn_q & sh_sel[PW]}}, sh_sel};
        sat_res  = saturate(sat_in, WIDTH, s2_sgn_q);
    end

    // Result bits above WIDTH are always zero from the helper.
    assign unused_sat = ^sat_res[SAT_MAX_W-1:WIDTH];

    // Next-state for all stages: everything moves together on adv, otherwise holds.
    always_comb begin
        adv       = !vld_q[LATENCY-1] || out_ready;
        vld_d     = vld_q;
        pp_hh_d   = pp_hh_q;
        pp_hl_d   = pp_hl_q;
        pp_lh_d   = pp_lh_q;
        pp_ll_d   = pp_ll_q;
        s1_neg_d  = s1_neg_q;
        s1_sgn_d  = s1_sgn_q;
        s2_prod_d = s2_prod_q;
        s2_sgn_d  = s2_sgn_q;
        out_d     = out_q;
        q_d       = q_q;
        ovf_d     = ovf_q;
        if (adv) begin
            vld_d = {vld_q[LATENCY-2:0], in_valid};
            // Data registers only load behind a valid so bubbles leave them untouched.
            if (in_valid) begin
                pp_hh_d  = pp_hh;
                pp_hl_d  = pp_hl;
                pp_lh_d  = pp_lh;
                pp_ll_d  = pp_ll;
                s1_neg_d = signed_en & (x[WIDTH-1] ^ y[WIDTH-1]);
                s1_sgn_d = signed_en;
            end
            if (vld_q[0]) begin
                s2_prod_d = s1_neg_q ? -s2_mag : s2_mag;
                s2_sgn_d  = s1_sgn_q;
            end
            if (vld_q[1]) begin
                out_d = s2_prod_q;
                q_d   = sat_res[WIDTH-1:0];
                ovf_d = sat_res[SAT_MAX_W];
            end
        end
    end

    // Pipeline state; asynchronous reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            pp_hh_q   <= '0;
            pp_hl_q   <= '0;
            pp_lh_q   <= '0;
            pp_ll_q   <= '0;
            s1_neg_q  <= 1'b0;
            s1_sgn_q  <= 1'b0;
            s2_prod_q <= '0;
            s2_sgn_q  <= 1'b0;
            out_q     <= '0;
            q_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            pp_hh_q   <= pp_hh_d;
            pp_hl_q   <= pp_hl_d;
            pp_lh_q   <= pp_lh_d;
            pp_ll_q   <= pp_ll_d;
            s1_neg_q  <= s1_neg_d;
            s1_sgn_q  <= s1_sgn_d;
            s2_prod_q <= s2_prod_d;
            s2_sgn_q  <= s2_sgn_d;
            out_q     <= out_d;
            q_q       <= q_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[LATENCY-1];
    assign out       = out_q;
    assign q         = q_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Scoreboard bench for vedic_mul_pipe: directed vectors, randomized streaming
// with backpressure against an arithmetic reference model, and mid-flight reset.
module tb_vedic_mul_pipe;
    import mul_pkg::*;

    localparam int unsigned W      = 16;
    localparam int unsigned F      = 8;
    localparam int unsigned PW     = PROD_W;
    localparam int unsigned N_RAND = 10000;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [W-1:0]  q;
        logic          o;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          signed_en;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out;
    logic [W-1:0]  q;
    logic          ovf;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    always #5 clk = ~clk;

    vedic_mul_pipe #(.WIDTH(W), .FRAC(F)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .signed_en (signed_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .q         (q),
        .ovf       (ovf)
    );

    // Reference: exact integer product, then floor((p + 2^(F-1)) / 2^F), then clamp.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s);
        res_t   r;
        longint p, v, lo, hi;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'(a) * longint'(b);
        v  = p + ((F > 0) ? (longint'(1) << (F - 1)) : longint'(0));
        v  = v >>> F;
        lo = s ? -(longint'(1) << (W - 1)) : longint'(0);
        hi = s ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
        r.p = p[PW-1:0];
        if (v > hi) begin
            r.q = hi[W-1:0];
            r.o = 1'b1;
        end else if (v < lo) begin
            r.q = lo[W-1:0];
            r.o = 1'b1;
        end else begin
            r.q = v[W-1:0];
            r.o = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        int unsigned r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return '0;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h7FFF;
            4:       return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One isolated transaction with constant expectations and a latency check.
    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [PW-1:0] e_out,
                            input logic [W-1:0] e_q, input logic e_ovf);
        int n;
        @(negedge clk);
        x         = a;
        y         = b;
        signed_en = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(LATENCY));
        check({name, "_out"}, 64'(out), 64'(e_out));
        check({name, "_q"}, 64'(q), 64'(e_q));
        check({name, "_ovf"}, 64'(ovf), 64'(e_ovf));
    endtask

    // Monitor: pops the scoreboard on every output transfer and watches stalls.
    initial begin : monitor
        res_t exp;
        res_t held;
        bit   stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en || rst) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'({out, q, ovf}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got an unexpected result 0x%0h, expected none", out);
                end else begin
                    exp = sb.pop_front();
                    check("stream_out", 64'(out), 64'(exp.p));
                    check("stream_q", 64'(q), 64'(exp.q));
                    check("stream_ovf", 64'(ovf), 64'(exp.o));
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out, q, ovf};
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int accepted;
        int cycles;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        signed_en = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_q", 64'(q), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        directed("u_basic", 16'h0180, 16'h0200, 1'b0, 32'h0003_0000, 16'h0300, 1'b0);
        directed("s_neg", 16'hFF00, 16'h0100, 1'b1, 32'hFFFF_0000, 16'hFF00, 1'b0);
        directed("s_minmin", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 16'h7FFF, 1'b1);
        directed("s_rnd_pos", 16'h0001, 16'h0080, 1'b1, 32'h0000_0080, 16'h0001, 1'b0);
        directed("s_rnd_neg", 16'hFFFF, 16'h0080, 1'b1, 32'hFFFF_FF80, 16'h0000, 1'b0);
        directed("u_max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 16'hFFFF, 1'b1);
        directed("s_m1m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);

        // Randomized streaming with random backpressure and mixed modes.
        mon_en   = 1'b1;
        accepted = 0;
        cycles   = 0;
        while (accepted < N_RAND && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            x         = pick();
            y         = pick();
            signed_en = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                sb.push_back(model(x, y, signed_en));
                accepted++;
            end
        end
        check("stream_accepted", 64'(accepted), 64'(N_RAND));

        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles    = 0;
        while (sb.size() != 0 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        repeat (4) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        mon_en = 1'b0;

        // Fill all three stages behind a stalled consumer, then reset.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            x         = W'($urandom);
            y         = W'($urandom);
            signed_en = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out", 64'(out), 64'd0);
        check("midrst_q", 64'(q), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        directed("post_rst", 16'h0180, 16'h0200, 1'b0, 32'h0003_0000, 16'h0300, 1'b0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
